gobou_ctrl_seq: RTL and testbench
=================================

// Module: gobou_ctrl_seq
// PURPOSE
//  Head of the gobou ctrl_bus chain: master that originates start/valid/stop for
//  one fully-connected layer run. On req it streams one ctrl frame per output group
//  of CORE neurons and drives input/weight read addresses in lockstep with valid.
//  Downstream delay stages (bias, activation) consume this frame as ctrl_bus slaves.
//  Between groups it holds off D_DRAIN cycles so that each frame clears the pipeline.
// PARAMETERS
//  CORE     8   output neurons per group (weight word carries CORE weights)
//  LWIDTH   12  width of total_in / total_out
//  AWIDTH   14  memory address width
//  D_DRAIN  6   idle cycles after each stop before the next group's start
// PORTS
//  clk          in   1       clock
//  xrst         in   1       async reset, active-low
//  req          in   1       run request; sampled only in S_IDLE
//  total_in     in   LWIDTH  input vector length (frame length in valid cycles)
//  total_out    in   LWIDTH  output neurons; groups = ceil(total_out/CORE)
//  in_offset    in   AWIDTH  base address of input vector
//  w_offset     in   AWIDTH  base address of weights
//  ack          out  1       1 = idle/ready; 0 = run in progress
//  out_ctrl     ctrl_bus.master  start/valid/stop frame
//  mem_in_addr  out  AWIDTH  input read address, valid with out_ctrl.valid
//  mem_w_addr   out  AWIDTH  weight read address, valid with out_ctrl.valid
//  group_idx    out  LWIDTH  index of current output group (for writeback)
// BEHAVIOUR
//  - One clock; reset asynchronous active-low. All outputs registered.
//  - Reset values: ack=1, out_ctrl={0,0,0}, addresses=0, group_idx=0, state=S_IDLE.
//    Reset mid-run aborts immediately; no stop is emitted; ack=1 after reset.
//  - FSM: S_IDLE -> S_PREP -> S_ACC -> S_DRAIN -> (S_ACC | S_IDLE).
//    S_IDLE: ack=1. req=1 at edge k latches total_in/total_out/offsets, ack=0 after k.
//      req while ack=0 is ignored (not queued).
//    S_PREP: one cycle; n_grp = ceil(total_out/CORE), i=0, g=0. If total_in==0 or
//      total_out==0: no frame emitted, go to S_IDLE, ack=1 after edge k+2.
//    S_ACC: valid=1 for exactly total_in cycles, first visible after edge k+2.
//      start=1 only on i==0; stop=1 only on i==total_in-1 (total_in==1: all three
//      high in the same cycle). mem_in_addr=in_offset+i;
//      mem_w_addr=w_offset+g*total_in+i (mod 2^AWIDTH, wrap silent).
//    S_DRAIN: ctrl all 0 for D_DRAIN cycles; then g++; if g==n_grp -> S_IDLE (ack=1),
//      else -> S_ACC with i=0. group_idx=g, held constant through the frame and drain.
//  - Invariants: start/stop single-cycle per frame; never valid without enclosing
//    start..stop; no valid in S_IDLE/S_PREP/S_DRAIN.
//  - Run length from req edge to ack=1: 2 + n_grp*(total_in + D_DRAIN) cycles.
//  - Counters i, g sized LWIDTH; g*total_in product computed as AWIDTH, truncated.
// STRUCTURE
//  - Shared package gobou.svh: ctrl_reg typedef {start,valid,stop}, ctrl_bus
//    interface, CORE, D_DRAIN, LWIDTH, AWIDTH constants, FSM state enum.
//  - One sub-module: gobou_ctrl_cnt (load/enable counter with terminal-count flag),
//    instantiated for i (max total_in-1), g (max n_grp-1) and drain (max D_DRAIN-1).
//  - Weight address via running accumulator (+total_in per group), no multiplier.
// TESTING
//  1 total_in=4,total_out=8, offsets 0/0: one frame; valid 4 cycles, start@i0,
//    stop@i3, mem_w_addr 0..3, ack low for 2+4+6=12 cycles.
//  2 total_in=3,total_out=20: 3 frames, group_idx 0,1,2; mem_w_addr 0-2,3-5,6-8;
//    exactly 6 ctrl-zero cycles between each stop and next start.
//  3 total_in=1,total_out=1: start=valid=stop=1 in one cycle; ack back after 9 cycles.
//  4 total_in=0 (or total_out=0): no start/valid/stop ever; ack=1 after edge k+2.
//  5 req held high through run and re-pulsed mid-frame: exactly one run executed;
//    new run starts only on req sampled after ack returns.
//  6 xrst asserted mid-S_ACC: outputs zero asynchronously, ack=1, no stop;
//    next req yields a clean full frame from i=0, g=0.

Source files
------------

// File: rtl/gobou_ctrl_seq_pkg.sv
// Shared constants, ctrl frame type and FSM state encoding for the gobou ctrl_bus chain head.
package gobou_ctrl_seq_pkg;

  localparam int unsigned CORE    = 8;
  localparam int unsigned LWIDTH  = 12;
  localparam int unsigned AWIDTH  = 14;
  localparam int unsigned D_DRAIN = 6;

  typedef struct packed {
    logic start;
    logic valid;
    logic stop;
  } ctrl_reg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PREP  = 2'd1;
  localparam logic [1:0] S_ACC   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/gobou_ctrl_cnt.sv
// Load/enable up-counter that wraps to zero after reaching max; tc flags cnt == max.
module gobou_ctrl_cnt #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         xrst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == max);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/gobou_ctrl_seq.sv
// ctrl_bus master for one fully-connected layer run: one start/valid/stop frame per
// output group, with input/weight read addresses driven alongside valid.
module gobou_ctrl_seq
  import gobou_ctrl_seq_pkg::*;
(
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [LWIDTH-1:0] total_in,
  input  logic [LWIDTH-1:0] total_out,
  input  logic [AWIDTH-1:0] in_offset,
  input  logic [AWIDTH-1:0] w_offset,
  output logic              ack,
  output ctrl_reg           out_ctrl,
  output logic [AWIDTH-1:0] mem_in_addr,
  output logic [AWIDTH-1:0] mem_w_addr,
  output logic [LWIDTH-1:0] group_idx
);

  typedef logic [LWIDTH:0] lw1_t;

  logic [1:0]        state_q, state_d;
  logic [LWIDTH-1:0] tin_q, tout_q, n_grp_q;
  logic [AWIDTH-1:0] in_off_q, w_base_q;
  logic              ack_q;
  ctrl_reg           ctrl_q;
  logic [AWIDTH-1:0] in_addr_q, w_addr_q;
  logic [LWIDTH-1:0] grp_q;

  logic              accept, in_prep, in_acc, in_drain, empty_run;
  logic [LWIDTH-1:0] i_cnt, g_cnt, d_cnt;
  logic              i_tc, g_tc, d_tc;
  lw1_t              grp_round;

  // ack low blocks acceptance until the cycle after the FSM is back in idle
  assign accept    = (state_q == S_IDLE) && ack_q && req;
  assign in_prep   = (state_q == S_PREP);
  assign in_acc    = (state_q == S_ACC);
  assign in_drain  = (state_q == S_DRAIN);
  assign empty_run = (tin_q == '0) || (tout_q == '0);
  assign grp_round = lw1_t'(tout_q) + lw1_t'(CORE - 1);

  gobou_ctrl_cnt #(.W(LWIDTH)) u_cnt_i (
    .clk  (clk),
    .xrst (xrst),
    .load (in_prep),
    .en   (in_acc),
    .max  (tin_q - LWIDTH'(1)),
    .cnt  (i_cnt),
    .tc   (i_tc)
  );

  gobou_ctrl_cnt #(.W(LWIDTH)) u_cnt_g (
    .clk  (clk),
    .xrst (xrst),
    .load (in_prep),
    .en   (in_drain && d_tc),
    .max  (n_grp_q - LWIDTH'(1)),
    .cnt  (g_cnt),
    .tc   (g_tc)
  );

  gobou_ctrl_cnt #(.W(LWIDTH)) u_cnt_d (
    .clk  (clk),
    .xrst (xrst),
    .load (in_prep),
    .en   (in_drain),
    .max  (LWIDTH'(D_DRAIN - 1)),
    .cnt  (d_cnt),
    .tc   (d_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_PREP;
      S_PREP:  state_d = empty_run ? S_IDLE : S_ACC;
      S_ACC:   if (i_tc) state_d = S_DRAIN;
      S_DRAIN: if (d_tc) state_d = g_tc ? S_IDLE : S_ACC;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q   <= S_IDLE;
      tin_q     <= '0;
      tout_q    <= '0;
      n_grp_q   <= '0;
      in_off_q  <= '0;
      w_base_q  <= '0;
      ack_q     <= 1'b1;
      ctrl_q    <= '0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      grp_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tin_q    <= total_in;
        tout_q   <= total_out;
        in_off_q <= in_offset;
        w_base_q <= w_offset;
      end
      if (in_prep) n_grp_q <= LWIDTH'(grp_round / lw1_t'(CORE));
      // Weight base steps by one input-vector length per group instead of g*total_in
      if (in_drain && d_tc && !g_tc) w_base_q <= w_base_q + AWIDTH'(tin_q);

      if (accept) ack_q <= 1'b0;
      else if (state_q == S_IDLE) ack_q <= 1'b1;

      ctrl_q.start <= in_acc && (i_cnt == '0);
      ctrl_q.valid <= in_acc;
      ctrl_q.stop  <= in_acc && i_tc;
      if (in_acc) begin
        in_addr_q <= in_off_q + AWIDTH'(i_cnt);
        w_addr_q  <= w_base_q + AWIDTH'(i_cnt);
      end
      grp_q <= g_cnt;
    end
  end

  assign ack         = ack_q;
  assign out_ctrl    = ctrl_q;
  assign mem_in_addr = in_addr_q;
  assign mem_w_addr  = w_addr_q;
  assign group_idx   = grp_q;

endmodule

// File: tb/tb_gobou_ctrl_seq.sv
// Self-checking bench for gobou_ctrl_seq: per-cycle expected frames from a scoreboard queue.
module tb_gobou_ctrl_seq;
  import gobou_ctrl_seq_pkg::*;

  logic              clk = 1'b0;
  logic              xrst;
  logic              req;
  logic [LWIDTH-1:0] total_in, total_out;
  logic [AWIDTH-1:0] in_offset, w_offset;
  logic              ack;
  ctrl_reg           out_ctrl;
  logic [AWIDTH-1:0] mem_in_addr, mem_w_addr;
  logic [LWIDTH-1:0] group_idx;

  gobou_ctrl_seq dut (
    .clk         (clk),
    .xrst        (xrst),
    .req         (req),
    .total_in    (total_in),
    .total_out   (total_out),
    .in_offset   (in_offset),
    .w_offset    (w_offset),
    .ack         (ack),
    .out_ctrl    (out_ctrl),
    .mem_in_addr (mem_in_addr),
    .mem_w_addr  (mem_w_addr),
    .group_idx   (group_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              ack;
    logic              start;
    logic              valid;
    logic              stop;
    logic [AWIDTH-1:0] in_addr;
    logic [AWIDTH-1:0] w_addr;
    logic [LWIDTH-1:0] grp;
  } exp_t;

  typedef struct {
    int tin;
    int tout;
    int io;
    int wo;
    bit hold;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vecs[6];

  task automatic push_rec(input logic a, input logic s, input logic v, input logic p,
                          input int ia, input int wa, input int g);
    exp_t e;
    e.ack = a; e.start = s; e.valid = v; e.stop = p;
    e.in_addr = AWIDTH'(ia); e.w_addr = AWIDTH'(wa); e.grp = LWIDTH'(g);
    sb.push_back(e);
  endtask

  // Expected outputs for each cycle after the accepting edge, up to and including ack=1
  task automatic push_run(input int tin, input int tout, input int io, input int wo);
    int n;
    n = (tin == 0 || tout == 0) ? 0 : (tout + CORE - 1) / CORE;
    push_rec(0, 0, 0, 0, 0, 0, 0);
    push_rec(0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < n; g++) begin
      for (int i = 0; i < tin; i++)
        push_rec(0, i == 0, 1, i == tin - 1, (io + i) % 16384, (wo + g * tin + i) % 16384, g);
      for (int d = 0; d < D_DRAIN; d++) push_rec(0, 0, 0, 0, 0, 0, 0);
    end
    push_rec(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic compare(input string name, input exp_t e);
    bit bad;
    bad = (ack !== e.ack) || (out_ctrl.start !== e.start) || (out_ctrl.valid !== e.valid) ||
          (out_ctrl.stop !== e.stop);
    if (e.valid && ((mem_in_addr !== e.in_addr) || (mem_w_addr !== e.w_addr) ||
                    (group_idx !== e.grp))) bad = 1;
    n_checks++;
    if (bad) begin
      n_err++;
      $display("FAIL %s t=%0t got ack=%b s/v/p=%b%b%b in=%0d w=%0d g=%0d want ack=%b s/v/p=%b%b%b in=%0d w=%0d g=%0d",
               name, $time, ack, out_ctrl.start, out_ctrl.valid, out_ctrl.stop, mem_in_addr,
               mem_w_addr, group_idx, e.ack, e.start, e.valid, e.stop, e.in_addr, e.w_addr,
               e.grp);
    end
  endtask

  task automatic start_run(input int tin, input int tout, input int io, input int wo);
    total_in  = LWIDTH'(tin);
    total_out = LWIDTH'(tout);
    in_offset = AWIDTH'(io);
    w_offset  = AWIDTH'(wo);
    req       = 1'b1;
    push_run(tin, tout, io, wo);
  endtask

  // Pop and compare one record per cycle; inputs are scrambled to prove they were latched
  task automatic drain_sb(input string name, input bit hold, input bit keep);
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      compare(name, e);
      req = hold && (sb.size() > 0 || keep);
      if (sb.size() > 0) begin
        total_in  = LWIDTH'($urandom_range(0, 50));
        total_out = LWIDTH'($urandom_range(0, 50));
        in_offset = AWIDTH'($urandom);
        w_offset  = AWIDTH'($urandom);
      end
    end
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{tin: 4, tout: 8,  io: 0,   wo: 0,     hold: 0};
    vecs[1] = '{tin: 3, tout: 20, io: 0,   wo: 0,     hold: 0};
    vecs[2] = '{tin: 1, tout: 1,  io: 0,   wo: 0,     hold: 0};
    vecs[3] = '{tin: 0, tout: 8,  io: 5,   wo: 5,     hold: 0};
    vecs[4] = '{tin: 5, tout: 0,  io: 5,   wo: 5,     hold: 1};
    vecs[5] = '{tin: 7, tout: 9,  io: 100, wo: 16380, hold: 0};

    xrst = 1'b0; req = 1'b0;
    total_in = '0; total_out = '0; in_offset = '0; w_offset = '0;
    repeat (2) @(negedge clk);
    e = '{ack: 1, start: 0, valid: 0, stop: 0, in_addr: 0, w_addr: 0, grp: 0};
    compare("reset", e);
    if (mem_in_addr !== '0 || mem_w_addr !== '0 || group_idx !== '0) begin
      n_err++;
      $display("FAIL reset_regs got in=%0d w=%0d g=%0d want 0/0/0", mem_in_addr, mem_w_addr,
               group_idx);
    end
    n_checks++;
    xrst = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      start_run(vecs[k].tin, vecs[k].tout, vecs[k].io, vecs[k].wo);
      drain_sb($sformatf("vec%0d", k), vecs[k].hold, 1'b0);
    end

    // req held high across a whole run, then still high after ack returns: second run follows
    @(negedge clk);
    start_run(2, 8, 10, 20);
    drain_sb("held_req", 1'b1, 1'b1);
    start_run(3, 8, 0, 5);
    drain_sb("after_ack", 1'b0, 1'b0);

    // Asynchronous reset part-way through a frame
    @(negedge clk);
    start_run(5, 16, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      compare("pre_abort", e);
      req = 1'b0;
    end
    sb.delete();
    #2 xrst = 1'b0;
    #1;
    e = '{ack: 1, start: 0, valid: 0, stop: 0, in_addr: 0, w_addr: 0, grp: 0};
    compare("abort", e);
    if (mem_in_addr !== '0 || mem_w_addr !== '0) begin
      n_err++;
      $display("FAIL abort_addr got in=%0d w=%0d want 0/0", mem_in_addr, mem_w_addr);
    end
    n_checks++;
    @(negedge clk);
    xrst = 1'b1;
    push_rec(1, 0, 0, 0, 0, 0, 0);
    push_rec(1, 0, 0, 0, 0, 0, 0);
    drain_sb("post_abort_idle", 1'b0, 1'b0);
    @(negedge clk);
    start_run(5, 16, 0, 0);
    drain_sb("post_abort_run", 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
